// File: rtl/gpio_debounce_16_if.sv
// Pin-conditioning bundle between raw board pins, the GPIO peripheral
// and the interrupt controller.
interface gpio_debounce_16_if #(
  parameter int WIDTH = 16
);
  logic [WIDTH-1:0] pin_i;
  logic [WIDTH-1:0] rise_en;
  logic [WIDTH-1:0] fall_en;
  logic [WIDTH-1:0] edge_clr;
  logic [WIDTH-1:0] gpio_in;
  logic [WIDTH-1:0] rise_o;
  logic [WIDTH-1:0] fall_o;
  logic [WIDTH-1:0] edge_pend;
  logic             intr;

  modport master (
    output pin_i,
    output rise_en,
    output fall_en,
    output edge_clr,
    input  gpio_in,
    input  rise_o,
    input  fall_o,
    input  edge_pend,
    input  intr
  );

  modport slave (
    input  pin_i,
    input  rise_en,
    input  fall_en,
    input  edge_clr,
    output gpio_in,
    output rise_o,
    output fall_o,
    output edge_pend,
    output intr
  );
endinterface

// File: rtl/gpio_debounce_16.sv
// Synchronise, debounce and edge-detect raw GPIO pins; sticky edge
// flags feed a level interrupt.
module gpio_debounce_16 #(
  parameter int WIDTH      = 16,
  parameter int PRESCALE   = 1000,
  parameter int STABLE_CNT = 4
) (
  input  logic              clk,
  input  logic              reset,
  gpio_debounce_16_if.slave io
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int CW = $clog2(STABLE_CNT + 1);
  localparam logic [PW-1:0] PMAX = PW'(PRESCALE - 1);
  localparam logic [CW-1:0] CMAX = CW'(STABLE_CNT - 1);

  logic [WIDTH-1:0] s1_q, s2_q;
  logic [PW-1:0]    presc_q, presc_d;
  logic [CW-1:0]    cnt_q [WIDTH];
  logic [CW-1:0]    cnt_d [WIDTH];
  logic [WIDTH-1:0] gpio_q, gpio_d;
  logic [WIDTH-1:0] rise_q, rise_d;
  logic [WIDTH-1:0] fall_q, fall_d;
  logic [WIDTH-1:0] pend_q, pend_d;
  logic             tick;

  always_comb begin
    tick    = (presc_q == PMAX);
    presc_d = tick ? '0 : presc_q + 1'b1;
    gpio_d  = gpio_q;
    rise_d  = '0;
    fall_d  = '0;
    cnt_d   = cnt_q;
    // A differing sample only counts on a tick; a matching one restarts.
    for (int i = 0; i < WIDTH; i++) begin
      if (tick) begin
        if (s2_q[i] == gpio_q[i]) begin
          cnt_d[i] = '0;
        end else if (cnt_q[i] == CMAX) begin
          cnt_d[i]  = '0;
          gpio_d[i] = s2_q[i];
          rise_d[i] = s2_q[i];
          fall_d[i] = ~s2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end
    end
    // Set wins over a simultaneous clear.
    pend_d = (pend_q & ~io.edge_clr)
           | (rise_q & io.rise_en)
           | (fall_q & io.fall_en);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_q    <= '0;
      s2_q    <= '0;
      presc_q <= '0;
      gpio_q  <= '0;
      rise_q  <= '0;
      fall_q  <= '0;
      pend_q  <= '0;
      for (int i = 0; i < WIDTH; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      s1_q    <= io.pin_i;
      s2_q    <= s1_q;
      presc_q <= presc_d;
      gpio_q  <= gpio_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
      pend_q  <= pend_d;
      cnt_q   <= cnt_d;
    end
  end

  assign io.gpio_in   = gpio_q;
  assign io.rise_o    = rise_q;
  assign io.fall_o    = fall_q;
  assign io.edge_pend = pend_q;
  assign io.intr      = |pend_q;

endmodule
